// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a multiplexed, active-low seven-segment bus.
// Recovers the hex value on each digit, flags illegal patterns and signals full frames.
module seg7_scan_decoder #(
  parameter int N_DIG         = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [6:0]           iSEG,
  input  logic [N_DIG-1:0]     iCOM,
  input  logic                 iERR_CLR,
  output logic [4*N_DIG-1:0]   oDIGITS,
  output logic [N_DIG-1:0]     oVALID,
  output logic                 oERR,
  output logic [3:0]           oERR_DIG,
  output logic                 oFRAME
);

  localparam logic [CNT_W-1:0] LP_CAP_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  logic [6:0]       r_s_seg;
  logic [6:0]       r_p_seg;
  logic [N_DIG-1:0] r_s_com;
  logic [N_DIG-1:0] r_p_com;
  logic [CNT_W-1:0] r_cnt;
  logic             r_captured;
  logic [N_DIG-1:0] r_seen;

  logic [N_DIG-1:0] w_sel;
  logic             w_legal_sel;
  logic             w_same;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_capture;
  logic [3:0]       w_idx;
  logic [3:0]       w_val;
  logic             w_is_hex;
  logic             w_is_blank;
  logic             w_illegal_cap;
  logic [N_DIG-1:0] w_seen_or;
  logic             w_frame;

  always_comb begin
    w_sel       = ~r_s_com;
    w_legal_sel = (w_sel != '0) && ((w_sel & (w_sel - N_DIG'(1))) == '0);
    w_idx       = 4'd0;
    for (int i = 0; i < N_DIG; i++) begin
      if (w_sel[i]) w_idx = 4'(i);
    end
    w_same = w_legal_sel && (r_s_seg == r_p_seg) && (r_s_com == r_p_com);
    if (!w_same)                  w_cnt_nxt = '0;
    else if (r_cnt == LP_CNT_MAX) w_cnt_nxt = r_cnt;
    else                          w_cnt_nxt = r_cnt + CNT_W'(1);
    // The !w_same term only matters for STABLE_CYCLES=1, where the first sample of a new pattern captures.
    w_capture = w_legal_sel && (w_cnt_nxt == LP_CAP_CNT) && (!r_captured || !w_same);
  end

  always_comb begin
    w_is_hex   = 1'b1;
    w_is_blank = 1'b0;
    w_val      = 4'h0;
    case (r_s_seg)
      7'b1000000: w_val = 4'h0;
      7'b1111001: w_val = 4'h1;
      7'b0100100: w_val = 4'h2;
      7'b0110000: w_val = 4'h3;
      7'b0011001: w_val = 4'h4;
      7'b0010010: w_val = 4'h5;
      7'b0000010: w_val = 4'h6;
      7'b1111000: w_val = 4'h7;
      7'b0000000: w_val = 4'h8;
      7'b0010000: w_val = 4'h9;
      7'b0001000: w_val = 4'hA;
      7'b0000011: w_val = 4'hB;
      7'b1000110: w_val = 4'hC;
      7'b0100001: w_val = 4'hD;
      7'b0000110: w_val = 4'hE;
      7'b0001110: w_val = 4'hF;
      7'b1111111: begin
        w_is_hex   = 1'b0;
        w_is_blank = 1'b1;
      end
      default: w_is_hex = 1'b0;
    endcase
    w_illegal_cap = w_capture && !w_is_hex && !w_is_blank;
    w_seen_or     = r_seen | w_sel;
    w_frame       = w_capture && (&w_seen_or);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_s_seg    <= '0;
      r_p_seg    <= '0;
      r_s_com    <= '0;
      r_p_com    <= '0;
      r_cnt      <= '0;
      r_captured <= 1'b0;
      r_seen     <= '0;
      oDIGITS    <= '0;
      oVALID     <= '0;
      oERR       <= 1'b0;
      oERR_DIG   <= 4'd0;
      oFRAME     <= 1'b0;
    end else begin
      r_s_seg <= iSEG;
      r_s_com <= iCOM;
      r_p_seg <= r_s_seg;
      r_p_com <= r_s_com;
      r_cnt   <= w_cnt_nxt;
      if (w_capture)   r_captured <= 1'b1;
      else if (!w_same) r_captured <= 1'b0;
      oFRAME <= w_frame;
      if (w_capture) begin
        r_seen <= w_frame ? '0 : w_seen_or;
        for (int i = 0; i < N_DIG; i++) begin
          if (w_sel[i]) begin
            oVALID[i] <= w_is_hex;
            if (w_is_hex) oDIGITS[4*i +: 4] <= w_val;
          end
        end
      end
      // A fresh illegal capture beats a same-cycle clear.
      if (w_illegal_cap) begin
        oERR     <= 1'b1;
        oERR_DIG <= w_idx;
      end else if (iERR_CLR) begin
        oERR <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares whenever the outputs change or oFRAME pulses.
module tb_seg7_scan_decoder;

  localparam int N  = 8;
  localparam int SC = 4;

  logic           iCLK = 1'b0;
  logic           iRST = 1'b1;
  logic [6:0]     iSEG = 7'h7F;
  logic [N-1:0]   iCOM = '1;
  logic           iERR_CLR = 1'b0;
  logic [4*N-1:0] oDIGITS;
  logic [N-1:0]   oVALID;
  logic           oERR;
  logic [3:0]     oERR_DIG;
  logic           oFRAME;

  seg7_scan_decoder #(.N_DIG(N), .STABLE_CYCLES(SC), .CNT_W(8)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSEG(iSEG), .iCOM(iCOM), .iERR_CLR(iERR_CLR),
    .oDIGITS(oDIGITS), .oVALID(oVALID), .oERR(oERR), .oERR_DIG(oERR_DIG), .oFRAME(oFRAME)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [4*N-1:0] dig;
    logic [N-1:0]   val;
    logic           err;
    logic [3:0]     ed;
    logic           fr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int frames = 0;
  bit mon_en = 1'b0;

  logic [4*N-1:0] m_dig;
  logic [N-1:0]   m_val;
  logic           m_err;
  logic [3:0]     m_ed;
  logic [N-1:0]   m_seen;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_state(input int at, input logic fr);
    exp_t e;
    e.cyc = at; e.dig = m_dig; e.val = m_val; e.err = m_err; e.ed = m_ed; e.fr = fr;
    q.push_back(e);
  endtask

  task automatic model_reset(input int at);
    m_dig = '0; m_val = '0; m_err = 1'b0; m_ed = 4'd0; m_seen = '0;
    push_state(at, 1'b0);
  endtask

  task automatic model_capture(input int idx, input logic [6:0] seg, input int at);
    logic [4*N-1:0] od;
    logic [N-1:0]   ov;
    logic           oe;
    logic [3:0]     oed;
    logic           hex;
    logic           fr;
    od = m_dig; ov = m_val; oe = m_err; oed = m_ed;
    hex = 1'b0;
    for (int v = 0; v < 16; v++) begin
      if (seg_tab[v] == seg) begin
        hex = 1'b1;
        m_dig[4*idx +: 4] = 4'(v);
      end
    end
    m_val[idx] = hex;
    if (!hex && seg != 7'h7F) begin
      m_err = 1'b1;
      m_ed  = 4'(idx);
    end
    m_seen[idx] = 1'b1;
    fr = &m_seen;
    if (fr) m_seen = '0;
    if (fr || od != m_dig || ov != m_val || oe != m_err || oed != m_ed) push_state(at, fr);
  endtask

  // Holds (digit idx, seg) for n edges; idx<0 drives the raw com value instead.
  task automatic dwell(input int idx, input logic [N-1:0] raw_com, input logic [6:0] seg,
                       input int n, input bit clr_on_cap);
    int c0;
    @(negedge iCLK);
    iCOM = (idx >= 0) ? ~(N'(1) << idx) : raw_com;
    iSEG = seg;
    c0 = cyc;
    if (idx >= 0 && n >= SC + 1) model_capture(idx, seg, c0 + SC + 1);
    for (int k = 1; k < n; k++) begin
      if (clr_on_cap && k == SC + 1) iERR_CLR = 1'b1;
      @(negedge iCLK);
      iERR_CLR = 1'b0;
    end
  endtask

  task automatic err_clear();
    @(negedge iCLK);
    iERR_CLR = 1'b1;
    if (m_err) begin
      m_err = 1'b0;
      push_state(cyc + 1, 1'b0);
    end
    @(negedge iCLK);
    iERR_CLR = 1'b0;
  endtask

  logic [4*N-1:0] p_dig;
  logic [N-1:0]   p_val;
  logic           p_err;
  logic [3:0]     p_ed;

  always @(negedge iCLK) begin
    if (mon_en) begin
      if (oFRAME === 1'b1) frames++;
      if (oFRAME !== 1'b0 || oDIGITS !== p_dig || oVALID !== p_val ||
          oERR !== p_err || oERR_DIG !== p_ed) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cycle %0d dig=%h val=%h err=%b ed=%0d fr=%b, none expected",
                   cyc, oDIGITS, oVALID, oERR, oERR_DIG, oFRAME);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.cyc != cyc || oDIGITS !== e.dig || oVALID !== e.val || oERR !== e.err ||
              oERR_DIG !== e.ed || oFRAME !== e.fr) begin
            errors++;
            $display("FAIL scoreboard: got cyc=%0d dig=%h val=%h err=%b ed=%0d fr=%b expected cyc=%0d dig=%h val=%h err=%b ed=%0d fr=%b",
                     cyc, oDIGITS, oVALID, oERR, oERR_DIG, oFRAME,
                     e.cyc, e.dig, e.val, e.err, e.ed, e.fr);
          end
        end
      end
    end
    p_dig = oDIGITS; p_val = oVALID; p_err = oERR; p_ed = oERR_DIG;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    m_dig = '0; m_val = '0; m_err = 1'b0; m_ed = 4'd0; m_seen = '0;
    repeat (3) @(negedge iCLK);
    check("reset_digits", oDIGITS, 32'h0);
    check("reset_valid", {24'h0, oVALID}, 32'h0);
    check("reset_err", {31'h0, oERR}, 32'h0);
    check("reset_err_dig", {28'h0, oERR_DIG}, 32'h0);
    check("reset_frame", {31'h0, oFRAME}, 32'h0);
    iRST = 1'b0;
    mon_en = 1'b1;

    // First capture: digit 0 shows 2, held long enough to prove no recapture.
    dwell(0, '1, 7'b0100100, 12, 1'b0);
    check("first_digit", {28'h0, oDIGITS[3:0]}, 32'h2);
    check("first_valid", {24'h0, oVALID}, 32'h01);

    // Full scan 0..7 with values 0..7; frame completes on digit 7.
    for (int d = 0; d < 8; d++) dwell(d, '1, seg_tab[d], 6, 1'b0);
    check("scan_digits", oDIGITS, 32'h76543210);
    check("scan_valid", {24'h0, oVALID}, 32'hFF);

    // Glitch on digit 3: the short-lived 6 must never land.
    dwell(3, '1, 7'b0000010, 3, 1'b0);
    dwell(3, '1, 7'b1111000, 6, 1'b0);
    check("glitch_digit3", {28'h0, oDIGITS[15:12]}, 32'h7);

    // Illegal pattern on digit 5 keeps the old value.
    dwell(5, '1, 7'b1010101, 6, 1'b0);
    check("illegal_err", {31'h0, oERR}, 32'h1);
    check("illegal_err_dig", {28'h0, oERR_DIG}, 32'h5);
    check("illegal_valid5", {31'h0, oVALID[5]}, 32'h0);
    check("illegal_keep5", {28'h0, oDIGITS[23:20]}, 32'h5);
    err_clear();
    repeat (2) @(negedge iCLK);
    check("err_cleared", {31'h0, oERR}, 32'h0);

    // Clear colliding with a new illegal capture: set wins.
    dwell(6, '1, 7'b1010101, 6, 1'b0);
    dwell(2, '1, 7'b0000001, 8, 1'b1);
    check("set_wins_err", {31'h0, oERR}, 32'h1);
    check("set_wins_dig", {28'h0, oERR_DIG}, 32'h2);

    // Two commons low: ignored entirely.
    dwell(-1, 8'b11111100, 7'b1000000, 10, 1'b0);

    // Blank after a 9 on digit 0.
    dwell(0, '1, 7'b0010000, 6, 1'b0);
    dwell(0, '1, 7'b1111111, 6, 1'b0);
    check("blank_valid0", {31'h0, oVALID[0]}, 32'h0);
    check("blank_keep0", {28'h0, oDIGITS[3:0]}, 32'h9);

    // Reset at dwell count 2, then capture STABLE_CYCLES+1 edges after release.
    @(negedge iCLK);
    iCOM = ~(N'(1) << 4);
    iSEG = 7'b0001000;
    c0 = cyc;
    repeat (4) @(negedge iCLK);
    iRST = 1'b1;
    model_reset(c0 + 5);
    @(negedge iCLK);
    iRST = 1'b0;
    model_capture(4, 7'b0001000, c0 + 10);
    repeat (8) @(negedge iCLK);
    check("post_reset_digits", oDIGITS, 32'h000A0000);
    check("post_reset_valid", {24'h0, oVALID}, 32'h10);

    repeat (4) @(negedge iCLK);
    check("frame_count", frames, 1);
    check("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
